alu16_top: RTL and testbench

- 16-bit unsigned registered ALU with four functional units: arithmetic, logic, compare and shift.
- A 4-bit function code selects the unit through alu_fun[3:2] and the operation through alu_fun[1:0].
- Each unit has its own registered result and "valid" flag. Only the selected unit's outputs are live in a given cycle.
- Sits as a datapath leaf driven by a controller that presents operands and opcode each cycle.

---
 rtl/alu16_pkg.sv | 40 ++++
 rtl/alu16_unit_decoder.sv | 34 +++
 rtl/alu16_top.sv | 130 +++++++++++++
 tb/tb_alu16_top.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu16_pkg.sv
// ============================================================================
// Module : alu16_pkg
// Brief  : Shared constants for the 16-bit registered ALU. These are the unit
//          selects, the full opcodes and the compare result codes.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package alu16_pkg;

    // Unit select, decoded from alu_fun[3:2]
    localparam logic [1:0] ARITH = 2'b00;
    localparam logic [1:0] LOGIC = 2'b01;
    localparam logic [1:0] CMP   = 2'b10;
    localparam logic [1:0] SHIFT = 2'b11;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_MUL   = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_AND   = 4'b0100;
    localparam logic [3:0] OP_OR    = 4'b0101;
    localparam logic [3:0] OP_NAND  = 4'b0110;
    localparam logic [3:0] OP_NOR   = 4'b0111;
    localparam logic [3:0] OP_NOP   = 4'b1000;
    localparam logic [3:0] OP_EQ    = 4'b1001;
    localparam logic [3:0] OP_GT    = 4'b1010;
    localparam logic [3:0] OP_LT    = 4'b1011;
    localparam logic [3:0] OP_SHR_A = 4'b1100;
    localparam logic [3:0] OP_SHL_A = 4'b1101;
    localparam logic [3:0] OP_SHR_B = 4'b1110;
    localparam logic [3:0] OP_SHL_B = 4'b1111;

    localparam logic [1:0] CMP_EQ = 2'd1;
    localparam logic [1:0] CMP_GT = 2'd2;
    localparam logic [1:0] CMP_LT = 2'd3;

endpackage

`default_nettype wire

// File: rtl/alu16_unit_decoder.sv
// ============================================================================
// Module : alu16_unit_decoder
// Brief  : Maps alu_fun[3:2] to four one-hot functional-unit enables.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu16_unit_decoder
    import alu16_pkg::*;
(
    input  logic [1:0] sel,
    output logic       en_ari,
    output logic       en_log,
    output logic       en_cmp,
    output logic       en_shift
);

    always_comb begin
        en_ari   = 1'b0;
        en_log   = 1'b0;
        en_cmp   = 1'b0;
        en_shift = 1'b0;
        case (sel)
            ARITH:   en_ari   = 1'b1;
            LOGIC:   en_log   = 1'b1;
            CMP:     en_cmp   = 1'b1;
            SHIFT:   en_shift = 1'b1;
            default: en_ari   = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/alu16_top.sv
// ============================================================================
// Module : alu16_top
// Brief  : Registered unsigned ALU with arithmetic, logic, compare and shift
//          units. Only the selected unit's result and flag are non-zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu16_top
    import alu16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rest,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       alu_fun,
    output logic [WIDTH-1:0] ari_out,
    output logic             carry_out,
    output logic             ari_flag,
    output logic [WIDTH-1:0] log_out,
    output logic             log_flag,
    output logic [WIDTH-1:0] cmp_out,
    output logic             cmp_flag,
    output logic [WIDTH-1:0] shift_out,
    output logic             shift_flag
);

    logic en_ari, en_log, en_cmp, en_shift;

    alu16_unit_decoder u_dec (
        .sel      (alu_fun[3:2]),
        .en_ari   (en_ari),
        .en_log   (en_log),
        .en_cmp   (en_cmp),
        .en_shift (en_shift)
    );

    logic [WIDTH:0]       sum;
    logic [WIDTH:0]       diff;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     quot;
    logic [WIDTH-1:0]     ari_res;
    logic                 ari_c;
    logic [WIDTH-1:0]     log_res;
    logic [WIDTH-1:0]     cmp_res;
    logic [WIDTH-1:0]     shift_res;

    // diff[WIDTH] is the borrow: set exactly when A < B
    assign sum  = {1'b0, A} + {1'b0, B};
    assign diff = {1'b0, A} - {1'b0, B};
    assign prod = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    assign quot = (B == '0) ? '1 : A / B;

    always_comb begin
        ari_res = '0;
        ari_c   = 1'b0;
        case (alu_fun)
            OP_ADD: begin ari_res = sum[WIDTH-1:0];  ari_c = sum[WIDTH];  end
            OP_SUB: begin ari_res = diff[WIDTH-1:0]; ari_c = diff[WIDTH]; end
            OP_MUL: begin
                ari_res = prod[WIDTH-1:0];
                ari_c   = |prod[2*WIDTH-1:WIDTH];
            end
            OP_DIV: begin ari_res = quot; ari_c = (B == '0); end
            default: ari_res = '0;
        endcase
    end

    always_comb begin
        log_res = '0;
        case (alu_fun)
            OP_AND:  log_res = A & B;
            OP_OR:   log_res = A | B;
            OP_NAND: log_res = ~(A & B);
            OP_NOR:  log_res = ~(A | B);
            default: log_res = '0;
        endcase
    end

    always_comb begin
        cmp_res = '0;
        case (alu_fun)
            OP_NOP:  cmp_res = '0;
            OP_EQ:   if (A == B) cmp_res = {{(WIDTH-2){1'b0}}, CMP_EQ};
            OP_GT:   if (A > B)  cmp_res = {{(WIDTH-2){1'b0}}, CMP_GT};
            OP_LT:   if (A < B)  cmp_res = {{(WIDTH-2){1'b0}}, CMP_LT};
            default: cmp_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (alu_fun)
            OP_SHR_A: shift_res = A >> 1;
            OP_SHL_A: shift_res = A << 1;
            OP_SHR_B: shift_res = B >> 1;
            OP_SHL_B: shift_res = B << 1;
            default:  shift_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rest) begin
        if (rest) begin
            ari_out    <= '0;
            carry_out  <= 1'b0;
            ari_flag   <= 1'b0;
            log_out    <= '0;
            log_flag   <= 1'b0;
            cmp_out    <= '0;
            cmp_flag   <= 1'b0;
            shift_out  <= '0;
            shift_flag <= 1'b0;
        end else begin
            ari_out    <= en_ari   ? ari_res   : '0;
            carry_out  <= en_ari & ari_c;
            ari_flag   <= en_ari;
            log_out    <= en_log   ? log_res   : '0;
            log_flag   <= en_log;
            cmp_out    <= en_cmp   ? cmp_res   : '0;
            cmp_flag   <= en_cmp;
            shift_out  <= en_shift ? shift_res : '0;
            shift_flag <= en_shift;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu16_top.sv
// ============================================================================
// Module : tb_alu16_top
// Brief  : Directed and randomized checks of alu16_top against an arithmetic
//          reference model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu16_top;

    logic        clk = 1'b0;
    logic        rest = 1'b1;
    logic [15:0] A = '0;
    logic [15:0] B = '0;
    logic [3:0]  alu_fun = '0;
    logic [15:0] ari_out, log_out, cmp_out, shift_out;
    logic        carry_out, ari_flag, log_flag, cmp_flag, shift_flag;

    int    n_vec = 0;
    int    n_err = 0;
    string ctx = "init";

    alu16_top #(.WIDTH(16)) dut (
        .clk        (clk),
        .rest       (rest),
        .A          (A),
        .B          (B),
        .alu_fun    (alu_fun),
        .ari_out    (ari_out),
        .carry_out  (carry_out),
        .ari_flag   (ari_flag),
        .log_out    (log_out),
        .log_flag   (log_flag),
        .cmp_out    (cmp_out),
        .cmp_flag   (cmp_flag),
        .shift_out  (shift_out),
        .shift_flag (shift_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s/%s: observed %h expected %h", ctx, tag, obs, exp);
        end
    endtask

    // Reference model computed from the opcode rules with plain integers
    task automatic model(input int a, input int b, input int f,
                         output int e_ari, output int e_c, output int e_log,
                         output int e_cmp, output int e_sh, output int e_unit);
        longint p;
        int op;
        op = f % 4;
        e_unit = f / 4;
        e_ari = 0; e_c = 0; e_log = 0; e_cmp = 0; e_sh = 0;
        case (e_unit)
            0: case (op)
                0: begin e_ari = (a + b) % 65536; e_c = (a + b > 65535) ? 1 : 0; end
                1: begin e_ari = (a - b + 65536) % 65536; e_c = (a < b) ? 1 : 0; end
                2: begin
                    p = longint'(a) * longint'(b);
                    e_ari = int'(p % 65536);
                    e_c = (p >= 65536) ? 1 : 0;
                end
                default: begin
                    if (b == 0) begin e_ari = 65535; e_c = 1; end
                    else e_ari = a / b;
                end
            endcase
            1: case (op)
                0: e_log = a & b;
                1: e_log = a | b;
                2: e_log = 65535 - (a & b);
                default: e_log = 65535 - (a | b);
            endcase
            2: case (op)
                0: e_cmp = 0;
                1: e_cmp = (a == b) ? 1 : 0;
                2: e_cmp = (a > b) ? 2 : 0;
                default: e_cmp = (a < b) ? 3 : 0;
            endcase
            default: case (op)
                0: e_sh = a / 2;
                1: e_sh = (a * 2) % 65536;
                2: e_sh = b / 2;
                default: e_sh = (b * 2) % 65536;
            endcase
        endcase
    endtask

    task automatic check_all(input int a, input int b, input int f);
        int e_ari, e_c, e_log, e_cmp, e_sh, e_unit;
        model(a, b, f, e_ari, e_c, e_log, e_cmp, e_sh, e_unit);
        check("ari_out",    {16'h0, ari_out},   e_ari);
        check("carry_out",  {31'h0, carry_out}, e_c);
        check("ari_flag",   {31'h0, ari_flag},  (e_unit == 0) ? 1 : 0);
        check("log_out",    {16'h0, log_out},   e_log);
        check("log_flag",   {31'h0, log_flag},  (e_unit == 1) ? 1 : 0);
        check("cmp_out",    {16'h0, cmp_out},   e_cmp);
        check("cmp_flag",   {31'h0, cmp_flag},  (e_unit == 2) ? 1 : 0);
        check("shift_out",  {16'h0, shift_out}, e_sh);
        check("shift_flag", {31'h0, shift_flag},(e_unit == 3) ? 1 : 0);
        check("onehot", 32'(ari_flag) + 32'(log_flag) + 32'(cmp_flag) + 32'(shift_flag), 1);
    endtask

    task automatic check_zero();
        check("ari_out",    {16'h0, ari_out},   0);
        check("carry_out",  {31'h0, carry_out}, 0);
        check("ari_flag",   {31'h0, ari_flag},  0);
        check("log_out",    {16'h0, log_out},   0);
        check("log_flag",   {31'h0, log_flag},  0);
        check("cmp_out",    {16'h0, cmp_out},   0);
        check("cmp_flag",   {31'h0, cmp_flag},  0);
        check("shift_out",  {16'h0, shift_out}, 0);
        check("shift_flag", {31'h0, shift_flag},0);
    endtask

    // Drive one vector away from the edge, then sample #1 after the edge
    task automatic apply(input int a, input int b, input int f);
        A = 16'(a);
        B = 16'(b);
        alu_fun = 4'(f);
        @(posedge clk);
        #1;
        check_all(a, b, f);
    endtask

    typedef struct { int a; int b; int f; } vec_t;
    vec_t dir[$];

    initial begin
        dir = '{
            '{3, 2, 0},  '{4, 2, 1},  '{3, 2, 2},  '{6, 2, 3},
            '{16'hFFFF, 1, 0}, '{1, 2, 1}, '{7, 0, 3}, '{16'hFFFF, 16'hFFFF, 2},
            '{3, 5, 4},  '{3, 5, 5},  '{3, 5, 6},  '{3, 5, 7},
            '{3, 5, 8},  '{3, 3, 9},  '{3, 1, 10}, '{1, 3, 11}, '{3, 1, 11},
            '{3, 4, 12}, '{3, 4, 13}, '{3, 4, 14}, '{3, 4, 15},
            '{16'h8000, 0, 13}, '{0, 16'h8000, 15}, '{0, 0, 0}
        };

        ctx = "reset_hold";
        #1;
        check_zero();
        @(posedge clk);
        #2;
        check_zero();
        rest = 1'b0;

        ctx = "directed";
        foreach (dir[i]) apply(dir[i].a, dir[i].b, dir[i].f);

        // Asynchronous reset mid-operation, away from any clock edge
        ctx = "async_reset";
        apply(3, 2, 0);
        #2;
        rest = 1'b1;
        #1;
        check_zero();
        @(posedge clk);
        #1;
        check_zero();
        #2;
        rest = 1'b0;
        @(posedge clk);
        #1;
        check_all(3, 2, 0);
        check("release_sum", {16'h0, ari_out}, 5);

        ctx = "sweep";
        for (int f = 0; f < 16; f++) apply(16'h1234, 16'h00F3, f);
        for (int f = 15; f >= 0; f--) apply(16'h00F3, 16'h00F3, f);

        ctx = "random";
        for (int k = 0; k < 400; k++) begin
            int ra, rb;
            ra = int'($urandom_range(0, 65535));
            rb = (k % 8 == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 65535));
            apply(ra, rb, int'($urandom_range(0, 15)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
